// File: rtl/float_to_int_double.sv
// IEEE-754 double to signed 64-bit integer, truncating toward zero.
// The significand is aligned by an iterative shifter moving SHIFT_STEP bits per cycle.
module float_to_int_double #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

    localparam logic [6:0]  STEP    = 7'(SHIFT_STEP);
    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    state_t      state;
    logic        sign_q, special_q, left_q, invalid_q, sticky_q;
    logic [63:0] sig_q, preset_q;
    logic [6:0]  d_rem;

    logic [10:0]        exp_f;
    logic [51:0]        man_f;
    logic signed [12:0] e_f;
    logic               cls_special, cls_invalid, cls_inexact, cls_left;
    logic [63:0]        cls_preset;
    logic [6:0]         cls_d;
    logic [6:0]         step;
    logic [63:0]        out_mask;

    assign exp_f    = a[62:52];
    assign man_f    = a[51:0];
    assign e_f      = $signed({2'b00, exp_f}) - 13'sd1023;
    assign in_ready = (state == IDLE);
    assign step     = (d_rem > STEP) ? STEP : d_rem;
    assign out_mask = (64'd1 << step) - 64'd1;

    // Classify the incoming operand so the accept edge can load everything at once.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cls_special = 1'b0;
        cls_invalid = 1'b0;
        cls_inexact = 1'b0;
        cls_left    = 1'b0;
        cls_preset  = 64'd0;
        cls_d       = 7'd0;
        if (exp_f == 11'h7FF) begin
            cls_special = 1'b1;
            cls_invalid = 1'b1;
            cls_preset  = (man_f != 52'd0 || !a[63]) ? INT_MAX : INT_MIN;
        end else if (e_f >= 13'sd63) begin
            cls_special = 1'b1;
            if (a[63] && e_f == 13'sd63 && man_f == 52'd0) begin
                cls_preset = INT_MIN;
            end else begin
                cls_invalid = 1'b1;
                cls_preset  = a[63] ? INT_MIN : INT_MAX;
            end
        end else if (e_f < 13'sd0) begin
            cls_special = 1'b1;
            cls_inexact = (exp_f != 11'd0) || (man_f != 52'd0);
        end else if (e_f >= 13'sd52) begin
            cls_left = 1'b1;
            cls_d    = 7'(e_f - 13'sd52);
        end else begin
            cls_d    = 7'(13'sd52 - e_f);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            left_q    <= 1'b0;
            invalid_q <= 1'b0;
            sticky_q  <= 1'b0;
            sig_q     <= 64'd0;
            preset_q  <= 64'd0;
            d_rem     <= 7'd0;
            out_valid <= 1'b0;
            result    <= 64'd0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q    <= a[63];
                        sig_q     <= {11'b0, 1'b1, man_f};
                        special_q <= cls_special;
                        preset_q  <= cls_preset;
                        invalid_q <= cls_invalid;
                        sticky_q  <= cls_inexact;
                        left_q    <= cls_left;
                        d_rem     <= cls_d;
                        state     <= (cls_d != 7'd0) ? SHIFT : FINISH;
                    end
                end
                SHIFT: begin
                    if (left_q) begin
                        sig_q <= sig_q << step;
                    end else begin
                        sig_q <= sig_q >> step;
                        if ((sig_q & out_mask) != 64'd0) sticky_q <= 1'b1;
                    end
                    d_rem <= d_rem - step;
                    if (d_rem == step) state <= FINISH;
                end
                FINISH: begin
                    // Magnitude is below 2^63 here, so negation cannot overflow.
                    if (special_q)   result <= preset_q;
                    else if (sign_q) result <= 64'd0 - sig_q;
                    else             result <= sig_q;
                    invalid   <= invalid_q;
                    inexact   <= sticky_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/float_to_int_double.md
# float_to_int_double

Sequential converter from IEEE-754 double precision to a signed 64-bit integer, rounding toward zero. It is the decode direction of the float64 datapath: it unpacks sign, exponent and mantissa and produces an integer, where the adder packs them. It sits behind the float64 arithmetic units on a valid/ready stream. It uses an iterative shifter of `SHIFT_STEP` bits per cycle, trading latency for area.

## Interface
Parameters:
- `SHIFT_STEP`, default 4: maximum shift distance applied per SHIFT cycle; legal range 1..16.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand `a` is valid.
- `in_ready` output 1: block accepts an operand; equals (state == IDLE).
- `a` input 64: float64 operand, laid out as {sign, exponent[10:0], mantissa[51:0]}.
- `out_valid` output 1: `result` and flags are valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output 64: signed two's-complement integer.
- `invalid` output 1: operand was NaN or Inf, or the truncated value is outside [-2^63, 2^63-1].
- `inexact` output 1: nonzero fraction bits were discarded.

## Operation
- States: IDLE, SHIFT, FINISH, DONE.
- **Accept:** an operand is accepted on an edge with `in_valid` && `in_ready`. On that edge:
  - Capture the sign.
  - Compute E = exponent - 1023.
  - Load the significand register (64-bit) with {11'b0, 1, mantissa}.
  - Classify the operand and set the shift direction and distance d.
- **Classes:**
  - Exponent 2047, NaN: result 0x7FFF_FFFF_FFFF_FFFF, invalid=1, d=0.
  - Exponent 2047, +Inf: result 0x7FFF_FFFF_FFFF_FFFF, invalid=1, d=0.
  - Exponent 2047, -Inf: result 0x8000_0000_0000_0000, invalid=1, d=0.
  - E ≥ 63, exactly -2^63 (sign=1, E=63, mantissa=0): result 0x8000_0000_0000_0000, no flags.
  - Any other E ≥ 63: saturate by sign as for Inf, invalid=1, d=0.
  - E < 0 (includes zeros and denormals): result 0, inexact = (exponent != 0 || mantissa != 0), d=0.
  - 52 ≤ E ≤ 62: left shift, d = E-52 (0..10).
  - 0 ≤ E < 52: right shift, d = 52-E (1..52).
- **Next state after accept:** SHIFT if d > 0, else FINISH.
- **SHIFT:** each cycle shifts by min(d_remaining, `SHIFT_STEP`) and decrements d_remaining by the same amount. On right shifts, every bit shifted out is ORed into the sticky inexact. Go to FINISH when d_remaining reaches 0.
- **FINISH:** for normal-range classes, result = sign ? -significand : significand; saturated and special classes keep their preset values. Register `result`, `invalid` and `inexact`; set `out_valid`=1; go to DONE.
- **DONE:** hold all outputs stable. On an edge with `out_valid` && `out_ready`: `out_valid`←0, go to IDLE. `in_ready` rises in the following cycle. No overlap of operations and no bypass.
- **Width rule:** magnitude after shifting is < 2^63 for E ≤ 62, so negation never overflows.

## Timing
- **Reset:** state IDLE, `out_valid`=0, `result`=0, `invalid`=0, `inexact`=0, `in_ready`=1, shifter and counters cleared.
- Reset asserted mid-operation aborts the operation; no result is produced.
- **Latency:** `out_valid` rises 1 + ceil(d/`SHIFT_STEP`) cycles after the accept edge.
  - Special, saturated and E < 0 cases: 1 cycle.
  - Worst case (d=52, STEP=4): 14 cycles.
- **Throughput:** one operation per (latency + 1 handshake cycle + 1 IDLE cycle) at minimum.
- `out_valid` never drops without `out_ready`. `result` and flags do not change while `out_valid`=1.
- `in_valid` while not IDLE is ignored; `a` need only be stable on the accept edge.

## Test plan
- 1.0 (0x3FF0_0000_0000_0000), STEP=4 -> result 1, invalid=0, inexact=0, `out_valid` 14 cycles after accept.
- -2.5 (0xC004_0000_0000_0000) -> result 0xFFFF_FFFF_FFFF_FFFE, inexact=1, invalid=0, latency 14.
- 2^62 (0x43D0_0000_0000_0000) -> result 0x4000_0000_0000_0000, left shift of 10, latency 4, no flags.
- -2^63 (0xC3E0_0000_0000_0000) -> 0x8000_0000_0000_0000 with no flags.
  - 2^63 (0x43E0_0000_0000_0000) -> 0x7FFF_FFFF_FFFF_FFFF, invalid=1.
  - NaN (0x7FF8_0000_0000_0000) -> 0x7FFF_FFFF_FFFF_FFFF, invalid=1.
  - -Inf (0xFFF0_0000_0000_0000) -> 0x8000_0000_0000_0000, invalid=1.
  - All four at latency 1.
- 0.5 (0x3FE0_0000_0000_0000) -> 0 with inexact=1; +0 -> 0 with no flags; smallest denormal (0x0000_0000_0000_0001) -> 0 with inexact=1.
- Hold `out_ready`=0 for 5 cycles after `out_valid` -> outputs stable, `in_ready`=0, a second `in_valid` is ignored.
- Pulse `rst_n` low mid-SHIFT -> `out_valid` stays 0, block returns to IDLE, the next operand converts correctly.
